self_reloading_down_counter: RTL and testbench

- Programmable down-counter/timer with load. Counts down from a captured reload value to zero, then either reloads (periodic) or stops (one-shot).
- Complements the up-counting self-reloading counter.
- Used as a period/timeout generator. Wrap and done flags feed downstream control logic.

---
 rtl/self_reloading_down_counter.sv | 114 +++++++++++
 tb/tb_self_reloading_down_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/self_reloading_down_counter.sv
// Programmable down-counter/timer with load, periodic reload or one-shot stop.
// Optional prescaler enabled by defining SRDC_PRESCALE_EN.
module self_reloading_down_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   input  logic             oneshot_i,
   output logic [WIDTH-1:0] count_o,
   output logic             wrap_o,
   output logic             done_o,
   output logic             running_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
   logic             running_q, running_d;
   logic             step_c;

   if ((PRESCALE < 2) || (PRESCALE > 256)) begin : g_bad_prescale
      $error("PRESCALE must be in 2..256");
   end

`ifdef SRDC_PRESCALE_EN
   localparam int unsigned PSW = $clog2(PRESCALE);

   logic [PSW-1:0] ps_q, ps_d;

   // A count step happens only on the enabled cycle that completes a prescale period.
   assign step_c = en_i && (ps_q == PSW'(PRESCALE - 1));

   always_comb begin
      ps_d = ps_q;
      if (load_i) begin
         ps_d = '0;
      end else if ((state_q == RUN) && en_i) begin
         ps_d = step_c ? '0 : ps_q + PSW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end
`else
   assign step_c = en_i;
`endif

   // Next-state: load beats zero handling beats decrement beats hold.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      wrap_d   = 1'b0;
      if (load_i) begin
         count_d  = load_val_i;
         reload_d = load_val_i;
         state_d  = RUN;
      end else if ((state_q == RUN) && step_c) begin
         if (count_q == '0) begin
            if (oneshot_i) begin
               state_d = DONE;
            end else begin
               count_d = reload_q;
               wrap_d  = 1'b1;
            end
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
      done_d    = (state_d == DONE);
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         wrap_q    <= 1'b0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         wrap_q    <= wrap_d;
         done_q    <= done_d;
         running_q <= running_d;
      end
   end

   assign count_o   = count_q;
   assign wrap_o    = wrap_q;
   assign done_o    = done_q;
   assign running_o = running_q;

endmodule

// File: tb/tb_self_reloading_down_counter.sv
// Directed self-checking bench for self_reloading_down_counter (WIDTH=4, PRESCALE=4).
module tb_self_reloading_down_counter;

   localparam int unsigned WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             load_i;
   logic [WIDTH-1:0] load_val_i;
   logic             en_i;
   logic             oneshot_i;
   logic [WIDTH-1:0] count_o;
   logic             wrap_o;
   logic             done_o;
   logic             running_o;

   int n_checks = 0;
   int n_errors = 0;

   self_reloading_down_counter #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .en_i       (en_i),
      .oneshot_i  (oneshot_i),
      .count_o    (count_o),
      .wrap_o     (wrap_o),
      .done_o     (done_o),
      .running_o  (running_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int val, input logic osh);
      load_i     = 1'b1;
      load_val_i = WIDTH'(val);
      oneshot_i  = osh;
      tick();
      load_i     = 1'b0;
   endtask

   initial begin
      int exp_cnt [8];
      int exp_wrp [8];
      int os_cnt  [6];
      int os_done [6];

      reset      = 1'b0;
      load_i     = 1'b0;
      load_val_i = '0;
      en_i       = 1'b1;
      oneshot_i  = 1'b0;

      // 1: reset state and idle after release
      repeat (3) tick();
      check("rst_count", int'(count_o), 0);
      check("rst_wrap", int'(wrap_o), 0);
      check("rst_done", int'(done_o), 0);
      check("rst_running", int'(running_o), 0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_count", int'(count_o), 0);
         check("idle_running", int'(running_o), 0);
      end

      // 2: periodic load 5
      exp_cnt = '{5, 4, 3, 2, 1, 0, 5, 4};
      exp_wrp = '{0, 0, 0, 0, 0, 0, 1, 0};
      load(5, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         check("per5_count", int'(count_o), exp_cnt[i]);
         check("per5_wrap", int'(wrap_o), exp_wrp[i]);
         check("per5_running", int'(running_o), 1);
      end

      // 3: one-shot load 3
      os_cnt  = '{3, 2, 1, 0, 0, 0};
      os_done = '{0, 0, 0, 0, 1, 1};
      load(3, 1'b1);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         check("os_count", int'(count_o), os_cnt[i]);
         check("os_done", int'(done_o), os_done[i]);
         check("os_running", int'(running_o), 1 - os_done[i]);
         check("os_wrap", int'(wrap_o), 0);
      end
      load(2, 1'b1);
      check("os_reload_count", int'(count_o), 2);
      check("os_reload_running", int'(running_o), 1);
      check("os_reload_done", int'(done_o), 0);

      // 4: reload mid-count, load at zero, enable low
      load(9, 1'b0);
      check("p9_count", int'(count_o), 9);
      for (int v = 8; v >= 2; v--) begin
         tick();
         check("p9_dec", int'(count_o), v);
      end
      load(9, 1'b0);
      check("p9_reload_count", int'(count_o), 9);
      check("p9_reload_wrap", int'(wrap_o), 0);
      for (int v = 8; v >= 0; v--) begin
         tick();
         check("p9_dec2", int'(count_o), v);
      end
      load(4, 1'b0);
      check("zero_load_count", int'(count_o), 4);
      check("zero_load_wrap", int'(wrap_o), 0);
      en_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_count", int'(count_o), 4);
         check("hold_wrap", int'(wrap_o), 0);
         check("hold_running", int'(running_o), 1);
      end
      en_i = 1'b1;
      tick();
      check("resume_count", int'(count_o), 3);

      // 5: reload value 0, then asynchronous reset mid-run
      load(0, 1'b0);
      check("z_load_count", int'(count_o), 0);
      check("z_load_wrap", int'(wrap_o), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("z_count", int'(count_o), 0);
         check("z_wrap", int'(wrap_o), 1);
      end
      load(7, 1'b0);
      check("pre_rst_count", int'(count_o), 7);
      reset = 1'b0;
      #1;
      check("async_rst_count", int'(count_o), 0);
      check("async_rst_wrap", int'(wrap_o), 0);
      check("async_rst_running", int'(running_o), 0);
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_count", int'(count_o), 0);

`ifdef SRDC_PRESCALE_EN
      // 6: prescaled stepping
      load(2, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         tick();
         check("ps_count", int'(count_o), (c < 4) ? 2 : (c < 8) ? 1 : (c < 12) ? 0 : 2);
         check("ps_wrap", int'(wrap_o), (c == 12) ? 1 : 0);
      end
      for (int c = 1; c <= 2; c++) begin
         tick();
         check("ps2_count", int'(count_o), 2);
      end
      en_i = 1'b0;
      repeat (2) begin
         tick();
         check("ps_stall", int'(count_o), 2);
      end
      en_i = 1'b1;
      tick();
      check("ps_stall_pre", int'(count_o), 2);
      tick();
      check("ps_stall_step", int'(count_o), 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
